// File: rtl/ternary_kernel_unpacker_pkg.sv
// ============================================================================
// Module  : ternary_kernel_unpacker_pkg
// Brief   : Shared kernel width, ternary code constants and FSM state type
//           for the ternary kernel unpacker.
//           This file also carries the network_params definitions
//           (`KERNEL_WIDTH). Compile it first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 4
`endif

package ternary_kernel_unpacker_pkg;

  // 2-bit packed ternary codes as written by the offline packer
  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_ILL  = 2'b10;
  localparam logic [1:0] TERN_NEG  = 2'b11;

  // Unpacker buffer state: nothing held, or a word being streamed out
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ternary_kernel_unpacker_decode.sv
// ============================================================================
// Module  : ternary_code_decode
// Brief   : Decodes one 2-bit ternary code into a sign-extended kernel value
//           and flags the reserved (illegal) code, which decodes to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_code_decode
  import ternary_kernel_unpacker_pkg::*;
(
  input  logic [1:0]                      i_code,
  output logic signed [`KERNEL_WIDTH-1:0] o_kernel,
  output logic                            o_illegal
);

  // Map the code onto 0 / +1 / -1; the reserved code yields 0 plus a flag
  always_comb begin
    o_kernel  = '0;
    o_illegal = 1'b0;
    case (i_code)
      TERN_POS: o_kernel  = {{(`KERNEL_WIDTH-1){1'b0}}, 1'b1};
      TERN_NEG: o_kernel  = '1;
      TERN_ILL: o_illegal = 1'b1;
      default:  o_kernel  = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ternary_kernel_unpacker.sv
// ============================================================================
// Module  : ternary_kernel_unpacker
// Brief   : Buffers one packed word of 2-bit ternary codes and streams it out
//           as LANES signed kernels per beat, LSB code first, flagging the
//           last beat of every filter.
//           Optional feature macro: TERNARY_ERR_EN (sticky err_code output
//           for reserved codes seen in an accepted beat).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_kernel_unpacker
  import ternary_kernel_unpacker_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int FILTER_LEN = 36
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORD_WIDTH-1:0]           in_word,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*`KERNEL_WIDTH-1:0]  out_kernel,
  output logic                            out_last
`ifdef TERNARY_ERR_EN
  ,
  output logic                            err_code
`endif
);

  localparam int c_kw        = `KERNEL_WIDTH;
  localparam int c_beat_bits = 2 * LANES;
  localparam int c_wb        = WORD_WIDTH / c_beat_bits;
  localparam int c_fb        = FILTER_LEN / LANES;
  localparam int c_bw        = (c_wb > 1) ? $clog2(c_wb) : 1;
  localparam int c_fw        = (c_fb > 1) ? $clog2(c_fb) : 1;
  localparam logic [c_bw-1:0] c_last_beat = c_bw'(c_wb - 1);
  localparam logic [c_fw-1:0] c_last_filt = c_fw'(c_fb - 1);

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  buf_q, buf_d;
  logic [c_bw-1:0]        beat_idx_q, beat_idx_d;
  logic [c_fw-1:0]        filt_cnt_q, filt_cnt_d;

  logic [c_wb-1:0][c_beat_bits-1:0] w_beats;
  logic [c_beat_bits-1:0]           w_beat;
  logic [LANES*c_kw-1:0]            w_kernel;
  logic [LANES-1:0]                 w_illegal;
  logic                             w_hold;
  logic                             w_last_beat;
  logic                             w_out_hs;
  logic                             w_in_hs;

  // View the held word as an array of beats and pick the current one
  assign w_beats = buf_q;
  assign w_beat  = w_beats[beat_idx_q];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ternary_code_decode u_decode (
      .i_code    (w_beat[2*g +: 2]),
      .o_kernel  (w_kernel[g*c_kw +: c_kw]),
      .o_illegal (w_illegal[g])
    );
  end

  // Handshake qualifiers; flush blocks both sides for the cycle
  assign w_hold      = (state_q == ST_HOLD);
  assign w_last_beat = (beat_idx_q == c_last_beat);
  assign w_out_hs    = w_hold & out_ready & ~flush;
  assign in_ready    = ~flush & (~w_hold | (w_last_beat & out_ready));
  assign w_in_hs     = in_valid & in_ready;

  // Outputs come only from registered state, never from in_*
  assign out_valid  = w_hold;
  assign out_kernel = w_hold ? w_kernel : '0;
  assign out_last   = w_hold & (filt_cnt_q == c_last_filt);

`ifdef TERNARY_ERR_EN
  logic err_q, err_d;
  assign err_code = err_q;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = |w_illegal;
`endif

  // Next-state: flush clears, else advance beats/filter count and load words
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    beat_idx_d = beat_idx_q;
    filt_cnt_d = filt_cnt_q;
`ifdef TERNARY_ERR_EN
    err_d      = err_q;
`endif
    if (flush) begin
      state_d    = ST_EMPTY;
      beat_idx_d = '0;
      filt_cnt_d = '0;
`ifdef TERNARY_ERR_EN
      err_d      = 1'b0;
`endif
    end else begin
      if (w_out_hs) begin
        filt_cnt_d = (filt_cnt_q == c_last_filt) ? '0 : filt_cnt_q + 1'b1;
`ifdef TERNARY_ERR_EN
        err_d      = err_q | (|w_illegal);
`endif
        if (w_last_beat) begin
          state_d = ST_EMPTY;
        end else begin
          beat_idx_d = beat_idx_q + 1'b1;
        end
      end
      if (w_in_hs) begin
        state_d    = ST_HOLD;
        buf_d      = in_word;
        beat_idx_d = '0;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      buf_q      <= '0;
      beat_idx_q <= '0;
      filt_cnt_q <= '0;
`ifdef TERNARY_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      beat_idx_q <= beat_idx_d;
      filt_cnt_q <= filt_cnt_d;
`ifdef TERNARY_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

`default_nettype wire
